// File: rtl/dotproduct_sequencer.sv
// Streaming front end for the combinational DotProduct core: packs (x, w) pairs into
// N-lane vectors, registers the signed result and offers it on a valid/ready port.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module DotProduct #(
  parameter int N          = `N,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ACC_WIDTH  = `ACC_WIDTH
) (
  input  logic [N*DATA_WIDTH-1:0] x,
  input  logic [N*DATA_WIDTH-1:0] w,
  output logic [ACC_WIDTH-1:0]    dp
);
  always_comb begin
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [2*DATA_WIDTH-1:0] prod;
    acc  = '0;
    prod = '0;
    for (int i = 0; i < N; i++) begin
      prod = $signed(x[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(w[i*DATA_WIDTH +: DATA_WIDTH]);
      acc  = acc + ACC_WIDTH'(prod);
    end
    dp = acc;
  end
endmodule

// state   | meaning
// LOAD    | accepting pairs into lane idx
// COMPUTE | capturing dp_comb into res (one cycle)
// OUT     | presenting res until out_ready
module dotproduct_sequencer #(
  parameter int N          = `N,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ACC_WIDTH  = `ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_dp,
  output logic                  busy
);
  localparam int IDX_W = $clog2(N);
  localparam int VEC_W = N * DATA_WIDTH;

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   x_vec_q, x_vec_d;
  logic [VEC_W-1:0]   w_vec_q, w_vec_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic [ACC_WIDTH-1:0] dp_comb;
  logic               accept;

  DotProduct #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dot (
    .x  (x_vec_q),
    .w  (w_vec_q),
    .dp (dp_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      x_vec_q <= '0;
      w_vec_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_vec_q <= x_vec_d;
      w_vec_q <= w_vec_d;
      res_q   <= res_d;
    end
  end

  assign accept = in_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_vec_d = x_vec_q;
    w_vec_d = w_vec_q;
    res_d   = res_q;
    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          x_vec_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_x;
          w_vec_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_w;
          // Explicit wrap keeps non-power-of-two N correct.
          if (idx_q == IDX_W'(N-1)) begin
            idx_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_COMPUTE: begin
        res_d   = dp_comb;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_OUT);
    out_dp    = res_q;
    busy      = (state_q != ST_LOAD) || (idx_q != '0);
  end
endmodule

// File: tb/tb_dotproduct_sequencer.sv
// Self-checking bench for dotproduct_sequencer: per-cycle model compare plus
// directed vectors with hand-computed results.
module tb_dotproduct_sequencer;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_w = '0;
  logic          in_ready, out_valid, busy;
  logic [AW-1:0] out_dp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: pairs collected so far, one result in flight, and its age in cycles.
  int fill = 0;
  int ax[N];
  int aw[N];
  bit pend = 1'b0;
  int age = 0;
  int exp_dp = 0;
  int hs_count = 0;
  int last_dp = 0;
  int hs_cyc[$];

  dotproduct_sequencer #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dp    (out_dp),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs seen at the negedge are what the following posedge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      fill = 0;
      pend = 1'b0;
      age  = 0;
    end else if (pend) begin
      age++;
    end
    check("in_ready", longint'(in_ready), longint'(!pend));
    check("out_valid", longint'(out_valid), longint'(pend && age >= 2));
    check("busy", longint'(busy), longint'(pend || fill != 0));
    if (pend && age >= 2) check("out_dp", longint'($signed(out_dp)), longint'(exp_dp));
    if (rst_n) begin
      if (!pend && in_valid) begin
        ax[fill] = $signed(in_x);
        aw[fill] = $signed(in_w);
        fill++;
        if (fill == N) begin
          exp_dp = 0;
          for (int i = 0; i < N; i++) exp_dp += ax[i] * aw[i];
          fill = 0;
          pend = 1'b1;
          age  = 0;
        end
      end else if (pend && age >= 2 && out_ready) begin
        pend = 1'b0;
        hs_count++;
        last_dp = $signed(out_dp);
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_pair(input int x, input int w);
    in_valid = 1'b1;
    in_x = DW'(x);
    in_w = DW'(w);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL accept_timeout: got no in_ready, expected accept within 64 cycles");
  endtask

  task automatic send_vec(input int xs[N], input int ws[N], input int gap);
    for (int i = 0; i < N; i++) begin
      send_pair(xs[i], ws[i]);
      if (gap > 0 && i < N-1) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 200; k++) begin
      if (hs_count >= target) return;
      @(posedge clk);
      #1;
    end
    tests++;
    fails++;
    $display("FAIL hs_timeout: got %0d handshakes, expected %0d", hs_count, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_dp", longint'($signed(out_dp)), 0);
    check("rst_busy", longint'(busy), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic
    out_ready = 1'b1;
    send_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 0);
    in_valid = 1'b0;
    t0 = cyc;
    wait_hs(1);
    check("basic_dp", longint'(last_dp), 70);
    if (hs_cyc.size() >= 1) check("basic_latency", longint'(hs_cyc[0] - t0), 1);
    check("basic_in_ready_after", longint'(in_ready), 1);

    // Signed extremes
    send_vec('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0);
    in_valid = 1'b0;
    wait_hs(2);
    check("extreme_dp", longint'(last_dp), 65536);
    send_vec('{127, -128, 1, -1}, '{-128, 127, 0, 5}, 0);
    in_valid = 1'b0;
    wait_hs(3);
    check("mixed_dp", longint'(last_dp), -32517);

    // Input gaps
    send_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 3);
    in_valid = 1'b0;
    wait_hs(4);
    check("gap_dp", longint'(last_dp), 70);

    // Backpressure
    out_ready = 1'b0;
    send_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 0);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = out_valid;
    end
    check("bp_out_valid_seen", longint'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_dp_stable", longint'($signed(out_dp)), 70);
      check("bp_in_ready_low", longint'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_out_valid_drop", longint'(out_valid), 0);
    check("bp_in_ready_back", longint'(in_ready), 1);
    check("bp_dp", longint'(last_dp), 70);

    // Reset mid-load
    send_pair(9, 9);
    send_pair(-7, 3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", longint'(in_ready), 1);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_dp", longint'($signed(out_dp)), 0);
    check("mid_rst_busy", longint'(busy), 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = hs_count;
    send_vec('{2, 2, 2, 2}, '{3, 3, 3, 3}, 0);
    in_valid = 1'b0;
    wait_hs(base + 1);
    check("post_rst_dp", longint'(last_dp), 24);

    // Throughput: expected 0, -20, -4 spaced 6 cycles apart
    base = hs_cyc.size();
    send_vec('{1, -1, 2, -2}, '{3, 3, 3, 3}, 0);
    send_vec('{10, 20, 30, 40}, '{1, -1, 1, -1}, 0);
    send_vec('{-5, 6, -7, 8}, '{-2, -2, -2, -2}, 0);
    in_valid = 1'b0;
    wait_hs(hs_count + 1);
    check("tput_last_dp", longint'(last_dp), -4);
    check("tput_count", longint'(hs_cyc.size() - base), 3);
    if (hs_cyc.size() >= base + 3) begin
      check("tput_gap1", longint'(hs_cyc[base+1] - hs_cyc[base]), 6);
      check("tput_gap2", longint'(hs_cyc[base+2] - hs_cyc[base+1]), 6);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
